sparq_cmd_scheduler: RTL

- Sits between the host command register file (CommandDataPort) and the execution units: A/A-meta/B/C AXI loaders, C storer, GEMM sequencer and PE reset.
- Assembles three-phase commands (X0/X1/X2) into a 6-word argument set.
- Checks busy and hazard state, then issues each command to exactly one unit through a valid/ready handshake.
- Tracks per-unit busy via done pulses and reports status on a StatePort.

---
 rtl/sparq_cmd_scheduler.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/sparq_cmd_scheduler.sv
// Command scheduler: assembles three-phase host commands, resolves unit hazards and issues to one
// execution unit. Define SPARQ_SCHED_PERF_EN to add stall counters on state6/state7.
module sparq_cmd_scheduler #(
  parameter int unsigned NUM_UNITS = 7,
  parameter int unsigned ARG_WORDS = 6,
  parameter int unsigned FSIZE     = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [2*FSIZE+8:0]           cmd_in,
  output logic                         cmd_ready,
  output logic [NUM_UNITS-1:0]         issue_valid,
  input  logic [NUM_UNITS-1:0]         issue_ready,
  output logic [ARG_WORDS*FSIZE-1:0]   issue_args,
  input  logic [NUM_UNITS-1:0]         unit_done,
  output logic [255:0]                 state_out
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArg1  = 3'd1,
    StArg2  = 3'd2,
    StCheck = 3'd3,
    StIssue = 3'd4
  } state_e;

  localparam logic [2:0] UnitCStore = 3'd4;
  localparam logic [2:0] UnitGemm   = 3'd5;
  localparam logic [2:0] UnitPe     = 3'd6;

  logic             cmd_valid;
  logic [7:0]       cmd_code;
  logic [FSIZE-1:0] cmd_d0, cmd_d1;
  assign {cmd_valid, cmd_code, cmd_d0, cmd_d1} = cmd_in;

  state_e                     state_q, state_d;
  logic [2:0]                 unit_q, unit_d;
  logic [7:0]                 code_q, code_d;
  logic [ARG_WORDS*FSIZE-1:0] args_q, args_d;
  logic [NUM_UNITS-1:0]       busy_q, busy_d;
  logic [1:0]                 err_q, err_d;
  logic [7:0]                 err_code_q, err_code_d;
  logic [31:0]                issued_q, issued_d;
  logic [7:0]                 last_code_q, last_code_d;
  logic [2:0]                 last_unit_q, last_unit_d;

  logic       dec_legal, dec_pe;
  logic [2:0] dec_unit;
  logic [1:0] dec_phase;
  logic [7:0] dec_off;
  logic       hazard;
  logic       bad;

  // Codes 5..19 pack five loaders at three phases each.
  always_comb begin
    dec_legal = 1'b0;
    dec_pe    = 1'b0;
    dec_unit  = 3'd0;
    dec_phase = 2'd0;
    dec_off   = cmd_code - 8'd5;
    if (cmd_code == 8'd1) begin
      dec_legal = 1'b1;
      dec_pe    = 1'b1;
      dec_unit  = UnitPe;
    end else if (cmd_code >= 8'd2 && cmd_code <= 8'd4) begin
      dec_legal = 1'b1;
      dec_unit  = UnitGemm;
      dec_phase = 2'(cmd_code - 8'd2);
    end else if (cmd_code >= 8'd5 && cmd_code <= 8'd19) begin
      dec_legal = 1'b1;
      dec_unit  = 3'(dec_off / 8'd3);
      dec_phase = 2'(dec_off % 8'd3);
    end
  end

  always_comb begin
    hazard = busy_q[unit_q];
    case (unit_q)
      3'd0, 3'd1, 3'd2: hazard = hazard | busy_q[5];
      3'd3:             hazard = hazard | busy_q[4] | busy_q[5];
      UnitCStore:       hazard = hazard | busy_q[5] | busy_q[3];
      UnitGemm:         hazard = hazard | (|busy_q[3:0]);
      UnitPe:           hazard = hazard | busy_q[5];
      default:          hazard = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    unit_d      = unit_q;
    code_d      = code_q;
    args_d      = args_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    issued_d    = issued_q;
    last_code_d = last_code_q;
    last_unit_d = last_unit_q;
    bad         = 1'b0;
    busy_d      = busy_q & ~unit_done;
    // PE reset has no done pulse; its busy bit lives for one cycle only.
    busy_d[UnitPe] = 1'b0;
    if (|(unit_done & ~busy_q)) err_d[1] = 1'b1;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (dec_legal && dec_pe) begin
            args_d  = '0;
            unit_d  = UnitPe;
            code_d  = cmd_code;
            state_d = StCheck;
          end else if (dec_legal && dec_phase == 2'd0) begin
            args_d                  = '0;
            args_d[0 +: 2*FSIZE]    = {cmd_d1, cmd_d0};
            unit_d                  = dec_unit;
            state_d                 = StArg1;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StArg1: begin
        if (cmd_valid) begin
          if (dec_legal && !dec_pe && dec_unit == unit_q && dec_phase == 2'd1) begin
            args_d[2*FSIZE +: 2*FSIZE] = {cmd_d1, cmd_d0};
            state_d                    = StArg2;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StArg2: begin
        if (cmd_valid) begin
          if (dec_legal && !dec_pe && dec_unit == unit_q && dec_phase == 2'd2) begin
            args_d[4*FSIZE +: 2*FSIZE] = {cmd_d1, cmd_d0};
            code_d                     = cmd_code;
            state_d                    = StCheck;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StCheck: begin
        if (!hazard) state_d = StIssue;
      end
      StIssue: begin
        if (issue_ready[unit_q]) begin
          busy_d[unit_q] = 1'b1;
          issued_d       = issued_q + 32'd1;
          last_code_d    = code_q;
          last_unit_d    = unit_q;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bad) begin
      args_d     = '0;
      state_d    = StIdle;
      err_d[0]   = 1'b1;
      err_code_d = cmd_code;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      unit_q      <= 3'd0;
      code_q      <= 8'd0;
      args_q      <= '0;
      busy_q      <= '0;
      err_q       <= 2'd0;
      err_code_q  <= 8'd0;
      issued_q    <= 32'd0;
      last_code_q <= 8'd0;
      last_unit_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      unit_q      <= unit_d;
      code_q      <= code_d;
      args_q      <= args_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      issued_q    <= issued_d;
      last_code_q <= last_code_d;
      last_unit_q <= last_unit_d;
    end
  end

  logic [31:0] perf_blk, perf_wait;

`ifdef SPARQ_SCHED_PERF_EN
  logic [31:0] blk_cnt_q, wait_cnt_q;
  logic        pe_issue;
  assign pe_issue = (state_q == StIssue) && (unit_q == UnitPe) && issue_ready[UnitPe];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt_q  <= 32'd0;
      wait_cnt_q <= 32'd0;
    end else if (pe_issue) begin
      blk_cnt_q  <= 32'd0;
      wait_cnt_q <= 32'd0;
    end else begin
      if (state_q == StCheck && hazard && blk_cnt_q != 32'hFFFF_FFFF) begin
        blk_cnt_q <= blk_cnt_q + 32'd1;
      end
      if (state_q == StIssue && !issue_ready[unit_q] && wait_cnt_q != 32'hFFFF_FFFF) begin
        wait_cnt_q <= wait_cnt_q + 32'd1;
      end
    end
  end
  assign perf_blk  = blk_cnt_q;
  assign perf_wait = wait_cnt_q;
`else
  assign perf_blk  = 32'd0;
  assign perf_wait = 32'd0;
`endif

  always_comb begin
    issue_valid = '0;
    if (state_q == StIssue) issue_valid[unit_q] = 1'b1;
  end

  assign cmd_ready  = (state_q == StIdle) || (state_q == StArg1) || (state_q == StArg2);
  assign issue_args = args_q;

  assign state_out = {perf_wait,
                      perf_blk,
                      32'd0,
                      32'd0,
                      {16'd0, last_code_q, 5'd0, last_unit_q},
                      issued_q,
                      {16'd0, err_code_q, 6'd0, err_q},
                      {22'd0, busy_q, state_q}};

endmodule
